// File: rtl/fir_tdm_ctrl.sv
// fir_tdm_ctrl: time-multiplexed FIR filter controller.
// A single signed MAC is stepped over N taps per input sample.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      sample handshake, in_data signed WIDTH
//   coef_we/addr/data      coefficient bank write port (IDLE only)
//   out_valid/out_ready    result handshake, out_data signed 2*WIDTH+4
//   busy                   high whenever a sample is in flight
module fir_tdm_ctrl #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   in_data,
   input  logic                      coef_we,
   input  logic [AW-1:0]             coef_addr,
   input  logic signed [WIDTH-1:0]   coef_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [2*WIDTH+3:0] out_data,
   output logic                      busy
);

   localparam int OW = 2*WIDTH+4;
   localparam int PW = 2*WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;

   state_t                  state_q, state_d;
   logic signed [OW-1:0]    acc_q, acc_d;
   logic signed [OW-1:0]    out_data_q, out_data_d;
   logic [AW-1:0]           k_q, k_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           new_ptr_q, new_ptr_d;
   logic signed [WIDTH-1:0] hist_q [N];
   logic signed [WIDTH-1:0] hist_d [N];
   logic signed [WIDTH-1:0] coef_q [N];
   logic signed [WIDTH-1:0] coef_d [N];
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;

   logic [AW-1:0]           rd_idx;
   logic signed [PW-1:0]    prod;
   logic signed [OW-1:0]    acc_sum;
   logic                    coef_ok;

   assign coef_ok = ({1'b0, coef_addr} < (AW+1)'(N));

   // Tap k reads x[n-k]; the subtraction wraps inside the N-entry ring.
   // When new_ptr < k the AW-bit sum may overflow, but the true result
   // lies in [0,N) so the modular arithmetic still lands on it.
   always_comb begin
      if (new_ptr_q >= k_q) begin
         rd_idx = new_ptr_q - k_q;
      end else begin
         rd_idx = new_ptr_q + AW'(N) - k_q;
      end
   end

   assign prod    = coef_q[k_q] * hist_q[rd_idx];
   assign acc_sum = acc_q + $signed({{4{prod[PW-1]}}, prod});

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      k_d         = k_q;
      wr_ptr_d    = wr_ptr_q;
      new_ptr_d   = new_ptr_q;
      hist_d      = hist_q;
      coef_d      = coef_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (coef_we && coef_ok) begin
               coef_d[coef_addr] = coef_data;
            end
            if (in_valid && in_ready_q) begin
               hist_d[wr_ptr_q] = in_data;
               new_ptr_d        = wr_ptr_q;
               wr_ptr_d         = (wr_ptr_q == AW'(N-1)) ?
                                  '0 : wr_ptr_q + AW'(1);
               acc_d            = '0;
               k_d              = '0;
               state_d          = MAC;
               in_ready_d       = 1'b0;
               busy_d           = 1'b1;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            if (k_q == AW'(N-1)) begin
               out_data_d  = acc_sum;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               k_d = k_q + AW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         out_data_q  <= '0;
         k_q         <= '0;
         wr_ptr_q    <= '0;
         new_ptr_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            hist_q[i] <= '0;
            coef_q[i] <= WIDTH'(i + 1);
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         k_q         <= k_d;
         wr_ptr_q    <= wr_ptr_d;
         new_ptr_q   <= new_ptr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         hist_q      <= hist_d;
         coef_q      <= coef_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// tb_fir_tdm_ctrl: directed bench for fir_tdm_ctrl with a sum-of-products
// reference model, a per-cycle result monitor and literal expectations.
module tb_fir_tdm_ctrl;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int OW = 2*W+4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [W-1:0]  in_data = '0;
   logic                 coef_we = 1'b0;
   logic [1:0]           coef_addr = '0;
   logic signed [W-1:0]  coef_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [OW-1:0] out_data;
   logic                 busy;

   logic                 rst3 = 1'b1;
   logic                 in_valid3 = 1'b0;
   logic                 in_ready3;
   logic signed [W-1:0]  in_data3 = '0;
   logic                 coef_we3 = 1'b0;
   logic [1:0]           coef_addr3 = '0;
   logic signed [W-1:0]  coef_data3 = '0;
   logic                 out_valid3;
   logic                 out_ready3 = 1'b1;
   logic signed [OW-1:0] out_data3;
   logic                 busy3;

   fir_tdm_ctrl #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   fir_tdm_ctrl #(.N(3), .WIDTH(W)) dut3 (
      .clk(clk), .rst(rst3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .coef_we(coef_we3), .coef_addr(coef_addr3), .coef_data(coef_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .busy(busy3)
   );

   int total = 0;
   int bad   = 0;

   int  mcoef [N];
   int  mx [$];
   int  expq [$];
   int  mon_e;
   time t_acc, t_prev;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // y[n] = sum_k coef[k] * x[n-k], missing history counts as zero
   function automatic int model_y();
      int s = 0;
      for (int k = 0; k < N; k++) begin
         if (k < mx.size()) s += mcoef[k] * mx[mx.size()-1-k];
      end
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mcoef[i] = i + 1;
      mx.delete();
      expq.delete();
   endtask

   // Every handshaken result is checked against the model queue.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            chk("model_out", longint'(out_data), mon_e);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic wcoef(input int a, input int v);
      coef_we = 1'b1;
      coef_addr = 2'(a);
      coef_data = W'(v);
      if (a < N) mcoef[a] = v;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic send(input int x, input int lit, input int hold,
                       input bit mac_we, input bit cw,
                       input int cwa, input int cwv);
      int cnt = 0;
      out_ready = (hold == 0);
      while (!in_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("in_ready_wait", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = W'(x);
      coef_we   = cw;
      coef_addr = 2'(cwa);
      coef_data = W'(cwv);
      if (cw && cwa < N) mcoef[cwa] = cwv;
      mx.push_back(x);
      expq.push_back(model_y());
      @(posedge clk);
      t_prev = t_acc;
      t_acc  = $time;
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         chk("mac_in_ready", in_ready, 0);
         chk("mac_busy", busy, 1);
         coef_we   = mac_we;
         coef_addr = 2'd0;
         coef_data = 8'sd77;
         @(posedge clk); #1;
         cnt++;
      end
      coef_we = 1'b0;
      chk("latency", cnt, N + 1);
      chk("lit_out", longint'(out_data), lit);
      in_valid = (hold > 0);
      in_data  = 8'sd99;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_data", longint'(out_data), lit);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
      chk("done_busy", busy, 0);
   endtask

   task automatic send3(input int x, input int lit);
      int cnt = 0;
      in_valid3 = 1'b1;
      in_data3  = W'(x);
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      while (!out_valid3 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("n3_out", longint'(out_data3), lit);
      @(posedge clk); #1;
   endtask

   initial begin
      int imp_lit [5];
      int step_lit [4];
      int ext_lit [4];
      imp_lit  = '{1, 2, 3, 4, 0};
      step_lit = '{-3, 12, 12, 18};
      ext_lit  = '{-16256, -32512, -48768, -65024};

      do_reset();

      for (int i = 0; i < 5; i++) begin
         send((i == 0) ? 1 : 0, imp_lit[i], 0, 1'b0, 1'b0, 0, 0);
         if (i > 0) chk("period", longint'((t_acc - t_prev) / 10), N + 2);
      end

      do_reset();
      send(2, 20, 0, 1'b0, 1'b1, 0, 10);

      do_reset();
      wcoef(0, -1);
      wcoef(1, 5);
      wcoef(2, 0);
      wcoef(3, 2);
      for (int i = 0; i < 4; i++)
         send(3, step_lit[i], (i == 1) ? 3 : 0, 1'b0, 1'b0, 0, 0);

      do_reset();
      for (int i = 0; i < N; i++) wcoef(i, 127);
      for (int i = 0; i < 4; i++)
         send(-128, ext_lit[i], 0, 1'b0, 1'b0, 0, 0);

      do_reset();
      for (int i = 0; i < 4; i++)
         send((i == 0) ? 1 : 0, imp_lit[i], 0, 1'b1, 1'b0, 0, 0);

      wcoef(1, 9);
      send(7, 7 + 9 * 0, 0, 1'b0, 1'b0, 0, 0);
      in_valid = 1'b1;
      in_data  = 8'sd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      for (int i = 0; i < 4; i++)
         send((i == 0) ? 1 : 0, imp_lit[i], 0, 1'b0, 1'b0, 0, 0);

      @(posedge clk); #1;
      rst3 = 1'b0;
      coef_we3   = 1'b1;
      coef_addr3 = 2'd3;
      coef_data3 = 8'sd99;
      @(posedge clk); #1;
      coef_we3 = 1'b0;
      send3(1, 1);
      send3(0, 2);
      send3(0, 3);
      send3(0, 0);

      chk("queue_empty", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
